// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder: FSM state encoding and a counter-width helper.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// CHUNK-bit ripple-carry adder slice; also exposes the carry into its top bit for overflow.
module adder_chunk #(
  parameter int unsigned CHUNK = 1
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             ctop
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[CHUNK];
  assign ctop = c[CHUNK-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder, CHUNK bits per clock, LS chunk first, valid/ready on both sides.
// Define SERIAL_ADDER_SUB_EN to add the 'sub' port (sum = a - b when sub=1).
module serial_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NCYC = WIDTH / CHUNK;
  localparam int unsigned CW   = cnt_width(NCYC);
  localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

  state_t state, state_next;

  logic [WIDTH-1:0] a_q, b_q, acc, acc_next;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic [CHUNK-1:0] chunk_s;
  logic             chunk_cout, chunk_ctop;
  logic [WIDTH-1:0] b_in;
  logic             carry_in;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_in     = sub ? ~b : b;
  assign carry_in = sub ? 1'b1 : cin;
`else
  assign b_in     = b;
  assign carry_in = cin;
`endif

  adder_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_q[CHUNK-1:0]),
    .b    (b_q[CHUNK-1:0]),
    .cin  (carry_q),
    .s    (chunk_s),
    .cout (chunk_cout),
    .ctop (chunk_ctop)
  );

  // Chunk results enter at the top and shift down, so after NCYC steps the word is aligned.
  assign acc_next = (acc >> CHUNK) | (WIDTH'(chunk_s) << (WIDTH - CHUNK));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        if (cnt == LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The shift accumulator is separate from sum so the last result stays put during the next RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b_in;
            carry_q <= carry_in;
            cnt     <= '0;
          end
        end
        RUN: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          carry_q <= chunk_cout;
          cnt     <= cnt + CW'(1);
          acc     <= acc_next;
          if (cnt == LAST) begin
            sum  <= acc_next;
            cout <= chunk_cout;
            ovf  <= chunk_ctop ^ chunk_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at CHUNK = 1, 4 and 8 (WIDTH = 8).
module tb_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  a, b;
  logic        cin, sub;
  logic [2:0]  iv, ir, ov, ordy;
  logic [7:0]  sm [3];
  logic [2:0]  co, of;
  int unsigned total = 0;
  int unsigned bad = 0;
  int          lat;
  logic [7:0]  held;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(ov[0]), .out_ready(ordy[0]), .sum(sm[0]), .cout(co[0]), .ovf(of[0])
  );

  serial_adder #(.WIDTH(8), .CHUNK(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(ov[1]), .out_ready(ordy[1]), .sum(sm[1]), .cout(co[1]), .ovf(of[1])
  );

  serial_adder #(.WIDTH(8), .CHUNK(8)) u_c8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(ov[2]), .out_ready(ordy[2]), .sum(sm[2]), .cout(co[2]), .ovf(of[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Accept one operation on instance k, scramble the operand inputs, then count edges to out_valid.
  task automatic start(input int k, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tc, input logic ts, output int n);
    a = ta; b = tb; cin = tc; sub = ts;
    check("in_ready_before_accept", 32'(ir[k]), 32'd1);
    iv[k] = 1'b1;
    @(posedge clk); #1;
    iv[k] = 1'b0;
    a = ~ta; b = ~tb; cin = ~tc; sub = ~ts;
    n = 0;
    while (!ov[k] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic finish_op(input int k);
    ordy[k] = 1'b1;
    @(posedge clk); #1;
    ordy[k] = 1'b0;
    check("out_valid_after_take", 32'(ov[k]), 32'd0);
    check("in_ready_after_take", 32'(ir[k]), 32'd1);
  endtask

  task automatic expect_result(input int k, input int n, input int exp_lat,
                               input logic [7:0] s, input logic c, input logic o);
    check("latency", 32'(n), 32'(exp_lat));
    check("sum", 32'(sm[k]), 32'(s));
    check("cout", 32'(co[k]), 32'(c));
    check("ovf", 32'(of[k]), 32'(o));
  endtask

  initial begin
    iv = '0; ordy = '0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #1;
    check("rst_out_valid", 32'(ov[0]), 32'd0);
    check("rst_sum", 32'(sm[0]), 32'd0);
    check("rst_cout", 32'(co[0]), 32'd0);
    check("rst_ovf", 32'(of[0]), 32'd0);
    check("rst_in_ready", 32'(ir[0]), 32'd1);
    #21 rst_n = 1'b1;
    @(posedge clk); #1;

    start(0, 8'h0F, 8'h01, 1'b0, 1'b0, lat);
    expect_result(0, lat, 8, 8'h10, 1'b0, 1'b0);
    finish_op(0);

    start(0, 8'hFF, 8'h01, 1'b0, 1'b0, lat);
    expect_result(0, lat, 8, 8'h00, 1'b1, 1'b0);
    finish_op(0);

    start(0, 8'h7F, 8'h01, 1'b0, 1'b0, lat);
    expect_result(0, lat, 8, 8'h80, 1'b0, 1'b1);

    // Backpressure: result must hold and new requests must be refused.
    for (int i = 0; i < 5; i++) begin
      a = 8'h33; b = 8'h44;
      iv[0] = (i % 2 == 0);
      @(posedge clk); #1;
      check("bp_out_valid", 32'(ov[0]), 32'd1);
      check("bp_in_ready", 32'(ir[0]), 32'd0);
      check("bp_sum", 32'(sm[0]), 32'h80);
      check("bp_cout", 32'(co[0]), 32'd0);
      check("bp_ovf", 32'(of[0]), 32'd1);
    end
    iv[0] = 1'b0;
    finish_op(0);
    @(posedge clk); #1;
    held = sm[0];
    check("sum_held_after_take", 32'(held), 32'h80);

    // Reset three cycles into an operation.
    a = 8'h55; b = 8'h22; cin = 1'b0;
    iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrun_rst_out_valid", 32'(ov[0]), 32'd0);
    check("midrun_rst_sum", 32'(sm[0]), 32'd0);
    check("midrun_rst_in_ready", 32'(ir[0]), 32'd1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_out_valid", 32'(ov[0]), 32'd0);

    start(0, 8'h12, 8'h34, 1'b0, 1'b0, lat);
    expect_result(0, lat, 8, 8'h46, 1'b0, 1'b0);
    finish_op(0);

    start(1, 8'hA5, 8'h5B, 1'b1, 1'b0, lat);
    expect_result(1, lat, 2, 8'h01, 1'b1, 1'b0);
    finish_op(1);

    start(2, 8'h40, 8'h40, 1'b0, 1'b0, lat);
    expect_result(2, lat, 1, 8'h80, 1'b0, 1'b1);
    finish_op(2);

`ifdef SERIAL_ADDER_SUB_EN
    start(0, 8'h10, 8'h01, 1'b1, 1'b1, lat);
    expect_result(0, lat, 8, 8'h0F, 1'b1, 1'b0);
    finish_op(0);

    start(0, 8'h80, 8'h01, 1'b0, 1'b1, lat);
    expect_result(0, lat, 8, 8'h7F, 1'b1, 1'b1);
    finish_op(0);

    start(1, 8'h05, 8'h07, 1'b0, 1'b1, lat);
    expect_result(1, lat, 2, 8'hFE, 1'b0, 1'b0);
    finish_op(1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
